// File: rtl/regfile_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | regfile_pkg -- shared state encoding and default register-file size |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
package regfile_pkg;

   localparam int DEF_DATA_W = 32;
   localparam int DEF_ADDR_W = 5;
   localparam int DEF_NRD    = 2;
   localparam int DEF_NWR    = 1;

   typedef enum logic [0:0] {
      INIT = 1'b0,
      RUN  = 1'b1
   } state_e;

endpackage
`default_nettype wire

// File: rtl/rf_read_port.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | rf_read_port -- one combinational read port with write bypass      |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module rf_read_port #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int NWR      = 1,
   parameter int ZERO_REG = 1
) (
   input  logic                  run,
   input  logic [ADDR_W-1:0]     rd_addr,
   input  logic [DATA_W-1:0]     stored_data,
   input  logic                  stored_busy,
   input  logic [NWR-1:0]        wr_ok,
   input  logic [NWR*ADDR_W-1:0] wr_addr,
   input  logic [NWR*DATA_W-1:0] wr_data,
   output logic [DATA_W-1:0]     rd_data,
   output logic                  rd_busy
);

   logic              hit;
   logic              is_zero;
   logic [DATA_W-1:0] byp_data;

   always_comb begin
      hit      = 1'b0;
      byp_data = '0;
      // ascending scan so the highest-index matching writer is the one kept
      for (int j = 0; j < NWR; j++) begin
         if (wr_ok[j] && (wr_addr[j*ADDR_W +: ADDR_W] == rd_addr)) begin
            hit      = 1'b1;
            byp_data = wr_data[j*DATA_W +: DATA_W];
         end
      end
      is_zero = (ZERO_REG != 0) && (rd_addr == '0);
      rd_data = '0;
      rd_busy = 1'b0;
      if (run && !is_zero) begin
         rd_data = hit ? byp_data : stored_data;
         rd_busy = stored_busy && !hit;
      end
   end

endmodule
`default_nettype wire

// File: rtl/regfile_mp.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | regfile_mp -- multi-port register file with busy scoreboard         |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module regfile_mp
   import regfile_pkg::*;
#(
   parameter int DATA_W   = DEF_DATA_W,
   parameter int ADDR_W   = DEF_ADDR_W,
   parameter int NRD      = DEF_NRD,
   parameter int NWR      = DEF_NWR,
   parameter int ZERO_REG = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NRD*ADDR_W-1:0] rd_addr,
   output logic [NRD*DATA_W-1:0] rd_data,
   output logic [NRD-1:0]        rd_busy,
   input  logic [NWR-1:0]        we,
   input  logic [NWR*ADDR_W-1:0] wr_addr,
   input  logic [NWR*DATA_W-1:0] wr_data,
   input  logic                  rsv_en,
   input  logic [ADDR_W-1:0]     rsv_addr,
   output logic                  init_done
);

   localparam int DEPTH = 2**ADDR_W;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;
   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] mem_d [DEPTH];
   logic [DEPTH-1:0]  busy_q, busy_d;

   logic              run;
   logic [NWR-1:0]    wr_ok;
   logic              rsv_ok;

   // rst is folded in so outputs read as idle during the reset cycle itself
   assign run       = (state_q == RUN) && !rst;
   assign init_done = run;

   always_comb begin
      for (int j = 0; j < NWR; j++) begin
         wr_ok[j] = run && we[j] &&
                    !((ZERO_REG != 0) && (wr_addr[j*ADDR_W +: ADDR_W] == '0));
      end
      rsv_ok = run && rsv_en && !((ZERO_REG != 0) && (rsv_addr == '0));
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      mem_d   = mem_q;
      busy_d  = busy_q;
      case (state_q)
         INIT: begin
            mem_d[cnt_q]  = '0;
            busy_d[cnt_q] = 1'b0;
            cnt_d         = cnt_q + {{(ADDR_W-1){1'b0}}, 1'b1};
            if (&cnt_q) begin
               state_d = RUN;
            end
         end
         RUN: begin
            for (int j = 0; j < NWR; j++) begin
               if (wr_ok[j]) begin
                  mem_d[wr_addr[j*ADDR_W +: ADDR_W]]  = wr_data[j*DATA_W +: DATA_W];
                  busy_d[wr_addr[j*ADDR_W +: ADDR_W]] = 1'b0;
               end
            end
            // applied after the writes so a same-cycle reserve keeps the entry pending
            if (rsv_ok) begin
               busy_d[rsv_addr] = 1'b1;
            end
         end
         default: state_d = INIT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= INIT;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
      mem_q  <= mem_d;
      busy_q <= busy_d;
   end

   generate
      for (genvar k = 0; k < NRD; k++) begin : g_rd
         rf_read_port #(
            .DATA_W   (DATA_W),
            .ADDR_W   (ADDR_W),
            .NWR      (NWR),
            .ZERO_REG (ZERO_REG)
         ) u_rd (
            .run         (run),
            .rd_addr     (rd_addr[k*ADDR_W +: ADDR_W]),
            .stored_data (mem_q[rd_addr[k*ADDR_W +: ADDR_W]]),
            .stored_busy (busy_q[rd_addr[k*ADDR_W +: ADDR_W]]),
            .wr_ok       (wr_ok),
            .wr_addr     (wr_addr),
            .wr_data     (wr_data),
            .rd_data     (rd_data[k*DATA_W +: DATA_W]),
            .rd_busy     (rd_busy[k])
         );
      end
   endgenerate

endmodule
`default_nettype wire

// File: tb/tb_regfile_mp.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_regfile_mp -- directed stimulus with queued expected responses  |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module tb_regfile_mp;

   localparam int DW  = 32;
   localparam int AW  = 5;
   localparam int NRD = 2;
   localparam int NWR = 2;

   logic              clk = 1'b0;
   logic              rst;
   logic [NRD*AW-1:0] rd_addr;
   logic [NRD*DW-1:0] rd_data;
   logic [NRD-1:0]    rd_busy;
   logic [NWR-1:0]    we;
   logic [NWR*AW-1:0] wr_addr;
   logic [NWR*DW-1:0] wr_data;
   logic              rsv_en;
   logic [AW-1:0]     rsv_addr;
   logic              init_done;

   typedef struct {
      string        name;
      int           port;
      logic [DW-1:0] data;
      logic         busy;
      logic         done;
   } exp_t;

   exp_t sb_q[$];
   int   n_cmp  = 0;
   int   n_fail = 0;

   regfile_mp #(
      .DATA_W(DW), .ADDR_W(AW), .NRD(NRD), .NWR(NWR), .ZERO_REG(1)
   ) dut (
      .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data),
      .rd_busy(rd_busy), .we(we), .wr_addr(wr_addr), .wr_data(wr_data),
      .rsv_en(rsv_en), .rsv_addr(rsv_addr), .init_done(init_done)
   );

   always #5 clk = ~clk;

   // monitor: every expectation queued in a cycle is checked at the falling edge
   always @(negedge clk) begin
      while (sb_q.size() > 0) begin
         exp_t e;
         e = sb_q.pop_front();
         n_cmp++;
         if (rd_data[e.port*DW +: DW] !== e.data || rd_busy[e.port] !== e.busy ||
             init_done !== e.done) begin
            n_fail++;
            $display("FAIL %s port%0d: got data=%h busy=%b done=%b, want data=%h busy=%b done=%b",
                     e.name, e.port, rd_data[e.port*DW +: DW], rd_busy[e.port], init_done,
                     e.data, e.busy, e.done);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_rd(string nm, int k, logic [DW-1:0] d, logic b, logic dn);
      exp_t e;
      e.name = nm; e.port = k; e.data = d; e.busy = b; e.done = dn;
      sb_q.push_back(e);
   endtask

   task automatic set_rd(int k, logic [AW-1:0] a);
      rd_addr[k*AW +: AW] = a;
   endtask

   task automatic set_wr(int j, logic [AW-1:0] a, logic [DW-1:0] d);
      we[j] = 1'b1;
      wr_addr[j*AW +: AW] = a;
      wr_data[j*DW +: DW] = d;
   endtask

   task automatic idle();
      we = '0; rsv_en = 1'b0; wr_addr = '0; wr_data = '0; rsv_addr = '0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, want normal completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; rd_addr = '0; idle();
      tick();
      set_rd(0, 5'd5); set_rd(1, 5'd0);
      expect_rd("rst_hold", 0, '0, 1'b0, 1'b0);
      tick();
      rst = 1'b0;

      // clearing sweep: writes/reserves must be ignored, reads zero, done low
      for (int i = 0; i < 32; i++) begin
         idle();
         set_rd(0, AW'(i)); set_rd(1, 5'd2);
         set_wr(0, 5'd2, 32'hBAD0_0000 + DW'(i));
         rsv_en = 1'b1; rsv_addr = 5'd1;
         expect_rd("init_rd", 0, '0, 1'b0, 1'b0);
         if (i == 31) expect_rd("init_nobypass", 1, '0, 1'b0, 1'b0);
         tick();
      end
      idle();
      set_rd(0, 5'd2); set_rd(1, 5'd1);
      expect_rd("run_r2_cleared", 0, '0, 1'b0, 1'b1);
      expect_rd("run_r1_not_busy", 1, '0, 1'b0, 1'b1);
      tick();

      // write with same-cycle read
      idle(); set_wr(0, 5'd5, 32'hDEADBEEF); set_rd(0, 5'd5); set_rd(1, 5'd6);
      expect_rd("bypass_r5", 0, 32'hDEADBEEF, 1'b0, 1'b1);
      expect_rd("other_r6", 1, '0, 1'b0, 1'b1);
      tick();
      idle();
      expect_rd("stored_r5", 0, 32'hDEADBEEF, 1'b0, 1'b1);
      tick();
      expect_rd("stored_r5_again", 0, 32'hDEADBEEF, 1'b0, 1'b1);
      tick();

      // both ports to r7: higher port wins
      idle(); set_wr(0, 5'd7, 32'h11); set_wr(1, 5'd7, 32'h22); set_rd(0, 5'd7);
      expect_rd("dual_bypass_r7", 0, 32'h22, 1'b0, 1'b1);
      tick();
      idle();
      expect_rd("dual_stored_r7", 0, 32'h22, 1'b0, 1'b1);
      tick();

      // independent writes on both ports
      idle(); set_wr(0, 5'd10, 32'hA); set_wr(1, 5'd11, 32'hB);
      set_rd(0, 5'd10); set_rd(1, 5'd11);
      expect_rd("bypass_r10", 0, 32'hA, 1'b0, 1'b1);
      expect_rd("bypass_r11", 1, 32'hB, 1'b0, 1'b1);
      tick();
      idle();
      expect_rd("stored_r10", 0, 32'hA, 1'b0, 1'b1);
      expect_rd("stored_r11", 1, 32'hB, 1'b0, 1'b1);
      tick();

      // zero register
      idle(); set_wr(0, 5'd0, 32'h1234); rsv_en = 1'b1; rsv_addr = 5'd0;
      set_rd(0, 5'd0); set_rd(1, 5'd0);
      expect_rd("zero_bypass", 0, '0, 1'b0, 1'b1);
      tick();
      idle();
      expect_rd("zero_stored", 0, '0, 1'b0, 1'b1);
      expect_rd("zero_stored_p1", 1, '0, 1'b0, 1'b1);
      tick();

      // scoreboard on r9
      idle(); rsv_en = 1'b1; rsv_addr = 5'd9; set_rd(0, 5'd9); set_rd(1, 5'd9);
      expect_rd("rsv_same_cycle", 0, '0, 1'b0, 1'b1);
      tick();
      idle();
      expect_rd("busy_cyc1", 0, '0, 1'b1, 1'b1);
      expect_rd("busy_cyc1_p1", 1, '0, 1'b1, 1'b1);
      tick();
      expect_rd("busy_cyc2", 0, '0, 1'b1, 1'b1);
      tick();
      set_wr(1, 5'd9, 32'h55);
      expect_rd("busy_masked_bypass", 0, 32'h55, 1'b0, 1'b1);
      tick();
      idle();
      expect_rd("busy_cleared", 0, 32'h55, 1'b0, 1'b1);
      tick();
      set_wr(0, 5'd9, 32'h66); rsv_en = 1'b1; rsv_addr = 5'd9;
      expect_rd("rsv_wr_bypass", 0, 32'h66, 1'b0, 1'b1);
      tick();
      idle();
      expect_rd("rsv_wins", 0, 32'h66, 1'b1, 1'b1);
      tick();

      // reset in the middle of the clearing sweep
      rst = 1'b1;
      expect_rd("rst_run_outputs", 0, '0, 1'b0, 1'b0);
      tick();
      rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         expect_rd("reinit_a", 0, '0, 1'b0, 1'b0);
         tick();
      end
      rst = 1'b1;
      expect_rd("rst_mid_init", 0, '0, 1'b0, 1'b0);
      tick();
      rst = 1'b0;
      set_rd(0, 5'd5); set_rd(1, 5'd9);
      for (int i = 0; i < 32; i++) begin
         expect_rd("reinit_b", 0, '0, 1'b0, 1'b0);
         tick();
      end
      expect_rd("reinit_r5_cleared", 0, '0, 1'b0, 1'b1);
      expect_rd("reinit_r9_not_busy", 1, '0, 1'b0, 1'b1);
      tick();

      @(negedge clk);
      #1;
      n_cmp++;
      if (sb_q.size() != 0) begin
         n_fail++;
         $display("FAIL sb_drain: got %0d pending, want 0", sb_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32: width of each register in bits.
REQ-002 The block SHALL have parameter ADDR_W, default 5: register address width; DEPTH = 2**ADDR_W.
REQ-003 The block SHALL have parameter NRD, default 2: number of read ports (1..4).
REQ-004 The block SHALL have parameter NWR, default 1: number of write ports (1..2).
REQ-005 The block SHALL have parameter ZERO_REG, default 1: when 1, address 0 is hard-wired zero.
REQ-006 The block SHALL have port clk, input, 1: the single clock, all state updates on its rising edge.
REQ-007 The block SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-008 The block SHALL have port rd_addr, input, NRD*ADDR_W: read addresses, port k at bits [k*ADDR_W +: ADDR_W].
REQ-009 The block SHALL have port rd_data, output, NRD*DATA_W: read data, packed like rd_addr.
REQ-010 The block SHALL have port rd_busy, output, NRD: scoreboard pending flag per read port.
REQ-011 The block SHALL have port we, input, NWR: write enables.
REQ-012 The block SHALL have port wr_addr, input, NWR*ADDR_W: write addresses.
REQ-013 The block SHALL have port wr_data, input, NWR*DATA_W: write data.
REQ-014 The block SHALL have port rsv_en, input, 1: reserve (mark pending) request.
REQ-015 The block SHALL have port rsv_addr, input, ADDR_W: register to reserve.
REQ-016 The block SHALL have port init_done, output, 1: high once the array has been cleared.

Function
REQ-017 Reads SHALL be combinational: zero cycles from rd_addr to rd_data.
REQ-018 A read of address 0 with ZERO_REG=1 SHALL return 0 and rd_busy=0.
REQ-019 Bypass: if any we[j]=1 with wr_addr[j]=rd_addr[k] (and not the zero register), rd_data[k] SHALL equal that wr_data[j]; if several match, the highest j wins.
REQ-020 Otherwise rd_data[k] SHALL equal the stored value of register rd_addr[k].
REQ-021 Writes SHALL commit on the rising edge when we[j]=1, in state RUN, to a non-zero register (when ZERO_REG=1).
REQ-022 If two write ports target the same address in one cycle, the highest-index port SHALL be stored.
REQ-023 Scoreboard: rsv_en=1 in RUN SHALL set busy[rsv_addr] at the next edge; ignored for the zero register.
REQ-024 A committed write SHALL clear busy[wr_addr] at the next edge.
REQ-025 A reserve and a write to the same address in one cycle SHALL leave busy set (reserve wins).
REQ-026 rd_busy[k] SHALL be busy[rd_addr[k]] AND NOT (a bypassing write to rd_addr[k] is active this cycle).
REQ-027 The FSM SHALL have states INIT and RUN; INIT clears entry cnt (value 0, busy 0) each cycle, cnt counting 0..DEPTH-1.
REQ-028 INIT SHALL transition to RUN on the edge after clearing entry DEPTH-1; RUN SHALL remain in RUN until rst.
REQ-029 In INIT, rd_data SHALL be 0, rd_busy SHALL be 0, and we and rsv_en SHALL be ignored (no bypass).
REQ-030 init_done SHALL be 0 in INIT and 1 in RUN; clearing takes exactly DEPTH cycles after rst deasserts.

Reset
REQ-031 rst=1 at an edge SHALL force state INIT and cnt=0; this includes rst asserted mid-INIT, which restarts the clear.
REQ-032 While rst is high, init_done=0, rd_data=0 and rd_busy=0.
REQ-033 Register contents and busy bits SHALL be defined only through the INIT sweep; no reset fan-out to the array.

Structure
REQ-034 Package regfile_pkg SHALL hold the state enum (INIT, RUN) and the default DATA_W/ADDR_W/NRD/NWR constants.
REQ-035 One sub-module, rf_read_port, SHALL implement a single read port (zero check, bypass priority, busy mask); it is instantiated NRD times through generate.

Verification
REQ-036 Deassert rst, then 32 cycles -> init_done rises on cycle 32; all 32 reads before that return 0.
REQ-037 Write r5=0xDEADBEEF while reading r5 in the same cycle -> rd_data=0xDEADBEEF that cycle, and on all later reads.
REQ-038 NWR=2, both ports write r7 (0x11, 0x22) -> bypass and stored value are 0x22.
REQ-039 Write r0=0x1234 and reserve r0 -> reads of r0 return 0 and rd_busy=0.
REQ-040 Reserve r9, then write r9=0x55 two cycles later -> rd_busy=1 for 2 cycles, 0 during the write cycle (bypass) and after; a same-cycle reserve plus write keeps rd_busy=1 the next cycle.
REQ-041 Assert rst at INIT cnt=10 -> init_done stays 0 and init_done rises exactly 32 cycles after rst drops.
